dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single-port word-organised data memory between two requesters.
- Port 0 is the CPU MEM stage and has priority. Port 1 is the loader/debug master, protected by an anti-starvation counter.
- Converts byte-enabled writes into merged whole-word writes, using the memory's combinational read data.
- Range-checks addresses and drives the memory's write strobe, address, data and PC-tag inputs.

Parameters:
- DM_WORDS, 4096, memory depth in 32-bit words; word index is addr[13:2].
- MAX_WAIT, 4, number of consecutive port-0 wins while port 1 waits, after which port 1 is forced to win.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- p0_req  in  1  port 0 request; held until p0_ack
- p0_we  in  1  port 0 write (1) / read (0)
- p0_be  in  4  port 0 byte enables; be[i] selects byte lane [8i+7:8i]
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data, lane-aligned
- p0_pc  in  32  PC tag forwarded to memory for the write trace
- p0_ack  out  1  one-cycle completion pulse
- p0_rdata  out  32  read data, valid while p0_ack=1
- p0_err  out  1  out-of-range flag, valid while p0_ack=1
- p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_pc, p1_ack, p1_rdata, p1_err  same as port 0, for port 1
- mem_we  out  1  memory write strobe
- mem_addr  out  32  byte address to memory
- mem_wdata  out  32  merged word
- mem_pc  out  32  PC tag to memory
- mem_rdata  in  32  combinational read data at mem_addr

Behaviour:
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Samples p0_req and p1_req at the rising edge.
  - If neither request is asserted, the FSM stays in IDLE.
  - Otherwise it latches the winner's we/be/addr/wdata/pc, records the winner id (sel), and moves to ACCESS.
- Arbitration:
  - Port 1 wins if p1_req=1 and (p0_req=0 or wait_cnt>=MAX_WAIT); otherwise port 0 wins.
  - wait_cnt increments (saturating at MAX_WAIT) on each IDLE decision where p1_req=1 and port 0 wins.
  - wait_cnt clears whenever port 1 wins.
- ACCESS (exactly one cycle):
  - mem_addr is the latched addr; mem_pc is the latched pc.
  - mem_wdata lane i = be[i] ? wdata lane i : mem_rdata lane i.
  - mem_we = latched we AND in_range AND be!=0 AND !reset.
  - in_range = (addr>>2) < DM_WORDS; addr[1:0] is ignored.
  - At the clock edge the write commits, and the response register captures mem_rdata, or 0 if out of range.
  - Next state: ACK.
- ACK (one cycle):
  - The selected port's ack=1, rdata=captured word, err=!in_range.
  - The other port's ack/rdata/err stay 0.
  - Next state: IDLE; requests are not sampled in ACK.
  - The requester drops or changes req in the cycle after ack.
- Timing:
  - Latency from req sampled in IDLE to ack is 2 cycles; throughput is one access per 3 cycles.
  - Read data reflects memory contents before any write in the same access.
- Outside ACCESS: mem_we=0, mem_addr/mem_wdata/mem_pc=0.
- Outside ACK: all ack/err outputs=0 and rdata=0.
- Out-of-range write: no memory write, err=1, rdata=0.
- be=0 write: no memory write, ack normal, err reflects range only.
- Simultaneous requests with wait_cnt<MAX_WAIT: port 0 wins and the port 1 request stays pending.
- Reset in any state:
  - Next state IDLE; wait_cnt=0; all outputs 0.
  - mem_we is forced 0 during the reset cycle, even in ACCESS.
  - An aborted access never acks.

Test Plan:
- Port 0 word write then read: write addr 0x10, be=1111, wdata 0xDEADBEEF → mem_we pulses 1 cycle with mem_addr 0x10, p0_ack 2 cycles after req. Read 0x10 → p0_rdata 0xDEADBEEF, p0_err=0.
- Byte merge: memory word 0x10 = 0x11223344; write be=0100, wdata 0x00AA0000 → mem_wdata 0x11AA3344; subsequent read returns 0x11AA3344.
- Starvation: p0_req and p1_req held continuously (MAX_WAIT=4) → grant order p0,p0,p0,p0,p1,p0,...; p1_ack after the 5th decision; wait_cnt returns to 0.
- Out of range: p1 write addr 0x4000 (word 4096) → mem_we stays 0, p1_ack=1 with p1_err=1 and p1_rdata=0; p1 read at 0x3FFC → err=0.
- Reset mid-access: assert reset in the ACCESS cycle of a write to 0x20 → mem_we=0 that cycle, no ack issued, word 0x20 unchanged; next request is serviced normally from IDLE.
- Idle / be=0: no requests for 10 cycles → all outputs 0. p0 write be=0000 to 0x30 → p0_ack=1, no write, word unchanged.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one word-organised data memory between the CPU
// MEM stage (port 0, priority) and the loader/debug master (port 1).
// Byte-enabled writes become read-merge-write of the whole word in a single
// ACCESS cycle, using the memory's combinational read data.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   pN_req/we/be       request, write strobe, byte-lane enables (N = 0, 1)
//   pN_addr/wdata/pc   byte address, lane-aligned write data, PC trace tag
//   pN_ack/rdata/err   one-cycle completion pulse, read word, out-of-range
//   mem_we/addr/wdata  memory write strobe, byte address, merged word
//   mem_pc             PC tag for the memory write trace
//   mem_rdata          combinational memory read data at mem_addr
module dm_port_arbiter #(
    parameter int unsigned DM_WORDS = 4096,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [3:0]  p0_be,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p0_pc,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [3:0]  p1_be,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [31:0] p1_pc,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned WCW   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      pc_q, pc_d;
    logic [WCW-1:0]   wait_q, wait_d;

    logic             p0_ack_d, p0_err_d, p1_ack_d, p1_err_d;
    logic [31:0]      p0_rdata_d, p1_rdata_d;

    logic             p1_win;
    logic             in_range;
    logic [31:0]      rd_word;
    logic [31:0]      merged;

    // Word index of the latched address must fall inside the array.
    assign in_range = (addr_q[31:2] < 30'(DM_WORDS));
    assign rd_word  = in_range ? mem_rdata : 32'd0;

    // Port 1 wins when port 0 is absent or port 1 has waited long enough.
    assign p1_win = p1_req && (!p0_req || (wait_q >= WCW'(MAX_WAIT)));

    // Lane merge of new write data over the current memory word.
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < int'(LANES); i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Next-state, request latch, starvation counter and response logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        wait_d     = wait_q;
        p0_ack_d   = 1'b0;
        p0_err_d   = 1'b0;
        p0_rdata_d = 32'd0;
        p1_ack_d   = 1'b0;
        p1_err_d   = 1'b0;
        p1_rdata_d = 32'd0;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d = ACCESS;
                    sel_d   = p1_win;
                    if (p1_win) begin
                        we_d    = p1_we;
                        be_d    = p1_be;
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                        pc_d    = p1_pc;
                        wait_d  = '0;
                    end else begin
                        we_d    = p0_we;
                        be_d    = p0_be;
                        addr_d  = p0_addr;
                        wdata_d = p0_wdata;
                        pc_d    = p0_pc;
                        // Port 1 lost this decision: age it, saturating.
                        if (p1_req && (wait_q < WCW'(MAX_WAIT))) begin
                            wait_d = wait_q + WCW'(1);
                        end
                    end
                end
            end

            ACCESS: begin
                state_d = ACK;
                if (!sel_q) begin
                    p0_ack_d   = 1'b1;
                    p0_err_d   = !in_range;
                    p0_rdata_d = rd_word;
                end else begin
                    p1_ack_d   = 1'b1;
                    p1_err_d   = !in_range;
                    p1_rdata_d = rd_word;
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            pc_q     <= 32'd0;
            wait_q   <= '0;
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= 32'd0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= 32'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            pc_q     <= pc_d;
            wait_q   <= wait_d;
            p0_ack   <= p0_ack_d;
            p0_err   <= p0_err_d;
            p0_rdata <= p0_rdata_d;
            p1_ack   <= p1_ack_d;
            p1_err   <= p1_err_d;
            p1_rdata <= p1_rdata_d;
        end
    end

    // Memory drive: only during ACCESS, and never in a reset cycle, since the
    // memory commits mem_wdata on the same edge that the reset takes effect.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_pc    = 32'd0;
        if ((state_q == ACCESS) && !reset) begin
            mem_we    = we_q && in_range && (be_q != 4'd0);
            mem_addr  = addr_q;
            mem_wdata = merged;
            mem_pc    = pc_q;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: behavioural memory, a reference
// memory image updated from transaction semantics, directed and random tests.
module tb_dm_port_arbiter;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned MAXW  = 4;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_addr, p0_wdata, p0_pc, p1_addr, p1_wdata, p1_pc;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;

    logic        preload;
    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    int checks;
    int errors;

    dm_port_arbiter #(.DM_WORDS(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_pc(p0_pc), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_pc(p1_pc), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_pc(mem_pc), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_3C3C;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Behavioural single-port memory with combinational read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr[13:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = (mem_addr[31:14] == 18'd0) ? mem[mem_addr[13:2]] : 32'hBAD0_BAD0;

    // Drives one request on one port, holds it until ack (bounded) and
    // reports what was observed.
    task automatic run_access(input int port, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] pc,
                              output int lat, output logic [31:0] rdata, output logic err,
                              output int we_pulses, output logic [31:0] wd_seen,
                              output logic [31:0] ad_seen, output logic [31:0] pc_seen,
                              output int other_acks);
        lat = -1; rdata = 32'd0; err = 1'b0; we_pulses = 0;
        wd_seen = 32'd0; ad_seen = 32'd0; pc_seen = 32'd0; other_acks = 0;
        @(negedge clk);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wdata; p0_pc = pc;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wdata; p1_pc = pc;
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_pulses++; wd_seen = mem_wdata; ad_seen = mem_addr; pc_seen = mem_pc;
            end
            if ((port == 0) ? p1_ack : p0_ack) other_acks++;
            if ((port == 0) ? p0_ack : p1_ack) begin
                lat   = k;
                rdata = (port == 0) ? p0_rdata : p1_rdata;
                err   = (port == 0) ? p0_err : p1_err;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        checks++;
        if ({p0_ack, p0_err, p1_ack, p1_err, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {p0_ack, p0_err, p1_ack, p1_err, mem_we});
        end
        checks++;
        if ((p0_rdata | p1_rdata) !== 32'd0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h want 0", p0_rdata, p1_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ((mem_addr | mem_wdata | mem_pc) !== 32'd0) begin
            errors++; $display("FAIL reset_mem_bus: got %h/%h/%h want 0", mem_addr, mem_wdata, mem_pc);
        end
    endtask

    task automatic test_write_read();
        int lat, we_n, oth; logic [31:0] rd, wd, ad, pc; logic er; logic [31:0] old;
        old = ref_mem[4];
        run_access(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0000_0400, lat, rd, er, we_n, wd, ad, pc, oth);
        ref_mem[4] = 32'hDEAD_BEEF;
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        checks++; if (we_n !== 1) begin errors++; $display("FAIL wr_we_pulses: got %0d want 1", we_n); end
        checks++; if ({ad, wd, pc} !== {32'h10, 32'hDEAD_BEEF, 32'h400}) begin
            errors++; $display("FAIL wr_mem_bus: got %h %h %h want 00000010 deadbeef 00000400", ad, wd, pc);
        end
        checks++; if ({er, rd} !== {1'b0, old}) begin
            errors++; $display("FAIL wr_resp: got err=%b %h want err=0 %h", er, rd, old);
        end
        checks++; if (oth !== 0) begin errors++; $display("FAIL wr_other_ack: got %0d want 0", oth); end
        run_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0, lat, rd, er, we_n, wd, ad, pc, oth);
        checks++; if ({er, rd} !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL rd_back: got err=%b %h want err=0 deadbeef", er, rd);
        end
        checks++; if (we_n !== 0) begin errors++; $display("FAIL rd_no_write: got %0d want 0", we_n); end
    endtask

    task automatic test_byte_merge();
        int lat, we_n, oth; logic [31:0] rd, wd, ad, pc; logic er;
        run_access(0, 1'b1, 4'hF, 32'h10, 32'h1122_3344, 32'h0, lat, rd, er, we_n, wd, ad, pc, oth);
        ref_mem[4] = 32'h1122_3344;
        run_access(0, 1'b1, 4'b0100, 32'h10, 32'h00AA_0000, 32'h8, lat, rd, er, we_n, wd, ad, pc, oth);
        ref_mem[4] = merge(ref_mem[4], 32'h00AA_0000, 4'b0100);
        checks++; if ({we_n, wd} !== {32'd1, 32'h11AA_3344}) begin
            errors++; $display("FAIL merge_wdata: got n=%0d %h want n=1 11aa3344", we_n, wd);
        end
        run_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0, lat, rd, er, we_n, wd, ad, pc, oth);
        checks++; if (rd !== ref_mem[4]) begin
            errors++; $display("FAIL merge_readback: got %h want %h", rd, ref_mem[4]);
        end
    endtask

    task automatic test_starvation();
        int exp_q[$]; int got_q[$]; int t_q[$]; int w; int both; int cyc; logic [31:0] p1_rd;
        w = 0;
        for (int i = 0; i < 10; i++) begin
            if (w >= int'(MAXW)) begin exp_q.push_back(1); w = 0; end
            else begin exp_q.push_back(0); w = (w + 1 > int'(MAXW)) ? int'(MAXW) : w + 1; end
        end
        both = 0; cyc = 0; p1_rd = 32'd0;
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_be = 4'hF; p0_addr = 32'h10;
        p1_req = 1'b1; p1_we = 1'b0; p1_be = 4'hF; p1_addr = 32'h14;
        while (got_q.size() < 10 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (p0_ack && p1_ack) both++;
            if (p0_ack) begin got_q.push_back(0); t_q.push_back(cyc); end
            else if (p1_ack) begin got_q.push_back(1); t_q.push_back(cyc); p1_rd = p1_rdata; end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        checks++; if (got_q.size() !== 10) begin
            errors++; $display("FAIL starve_timeout: got %0d grants want 10", got_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL starve_order[%0d]: got p%0d want p%0d", i, got_q[i], exp_q[i]);
                end
            end
            checks++; if (t_q[9] - t_q[0] !== 27) begin
                errors++; $display("FAIL starve_throughput: got %0d cycles want 27", t_q[9] - t_q[0]);
            end
        end
        checks++; if (both !== 0) begin errors++; $display("FAIL starve_dual_ack: got %0d want 0", both); end
        checks++; if (p1_rd !== ref_mem[5]) begin
            errors++; $display("FAIL starve_p1_rdata: got %h want %h", p1_rd, ref_mem[5]);
        end
    endtask

    task automatic test_out_of_range();
        int lat, we_n, oth; logic [31:0] rd, wd, ad, pc; logic er;
        run_access(1, 1'b1, 4'hF, 32'h4000, 32'h5555_AAAA, 32'h0, lat, rd, er, we_n, wd, ad, pc, oth);
        checks++; if ({lat, we_n, er, rd} !== {32'd2, 32'd0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL oor_write: got lat=%0d n=%0d err=%b %h want lat=2 n=0 err=1 0", lat, we_n, er, rd);
        end
        checks++; if (mem[0] !== ref_mem[0]) begin
            errors++; $display("FAIL oor_mem0: got %h want %h", mem[0], ref_mem[0]);
        end
        run_access(1, 1'b0, 4'hF, 32'h3FFC, 32'h0, 32'h0, lat, rd, er, we_n, wd, ad, pc, oth);
        checks++; if ({er, rd} !== {1'b0, ref_mem[4095]}) begin
            errors++; $display("FAIL last_word: got err=%b %h want err=0 %h", er, rd, ref_mem[4095]);
        end
        run_access(0, 1'b0, 4'hF, 32'h8000_0010, 32'h0, 32'h0, lat, rd, er, we_n, wd, ad, pc, oth);
        checks++; if ({er, rd} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL oor_high_addr: got err=%b %h want err=1 0", er, rd);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks; int lat, we_n, oth; logic [31:0] rd, wd, ad, pc; logic er;
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_be = 4'hF; p0_addr = 32'h20; p0_wdata = 32'hCAFE_F00D; p0_pc = 32'h44;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_access: got %b want 1", mem_we); end
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we_gate: got %b want 0", mem_we); end
        @(negedge clk);
        reset = 1'b0; p0_req = 1'b0;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            if (p0_ack || p1_ack) acks++;
            @(negedge clk);
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d want 0", acks); end
        checks++; if (mem[8] !== ref_mem[8]) begin
            errors++; $display("FAIL rst_word_kept: got %h want %h", mem[8], ref_mem[8]);
        end
        run_access(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h0, lat, rd, er, we_n, wd, ad, pc, oth);
        checks++; if ({lat, er, rd} !== {32'd2, 1'b0, ref_mem[8]}) begin
            errors++; $display("FAIL rst_recover: got lat=%0d err=%b %h want lat=2 err=0 %h", lat, er, rd, ref_mem[8]);
        end
    endtask

    task automatic test_idle_be0();
        int lat, we_n, oth; logic [31:0] rd, wd, ad, pc; logic er;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if ({p0_ack, p0_err, p1_ack, p1_err, mem_we, p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_pc} !== '0) begin
                errors++; $display("FAIL idle_outputs[%0d]: got ack=%b%b we=%b addr=%h want all 0", k, p0_ack, p1_ack, mem_we, mem_addr);
            end
        end
        run_access(0, 1'b1, 4'h0, 32'h30, 32'hFFFF_FFFF, 32'h0, lat, rd, er, we_n, wd, ad, pc, oth);
        checks++; if ({lat, we_n, er, rd} !== {32'd2, 32'd0, 1'b0, ref_mem[12]}) begin
            errors++; $display("FAIL be0_write: got lat=%0d n=%0d err=%b %h want lat=2 n=0 err=0 %h", lat, we_n, er, rd, ref_mem[12]);
        end
        checks++; if (mem[12] !== ref_mem[12]) begin
            errors++; $display("FAIL be0_word_kept: got %h want %h", mem[12], ref_mem[12]);
        end
    endtask

    task automatic test_random();
        int lat, we_n, oth, port, roll, bad; logic [31:0] rd, wd, ad, pc; logic er;
        logic we; logic [3:0] be; logic [31:0] addr, wdata, pcv, exp_rd, exp_wd;
        logic inr; int idx; int exp_n;
        for (int t = 0; t < 60; t++) begin
            port  = int'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            be    = 4'($urandom);
            wdata = $urandom;
            pcv   = $urandom;
            roll  = int'($urandom_range(0, 9));
            if (roll == 0) addr = 32'h4000 + ($urandom & 32'h0FFF_FFFF);
            else begin
                idx  = int'($urandom_range(0, 15)) + ((roll == 1) ? 4080 : 0);
                addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            end
            inr    = (addr < 32'h4000);
            idx    = int'(addr[13:2]);
            exp_rd = inr ? ref_mem[idx] : 32'd0;
            exp_wd = merge(ref_mem[idx], wdata, be);
            exp_n  = (we && inr && (be != 4'd0)) ? 1 : 0;
            run_access(port, we, be, addr, wdata, pcv, lat, rd, er, we_n, wd, ad, pc, oth);
            if (exp_n == 1) ref_mem[idx] = exp_wd;
            checks++;
            if ({lat, oth, er, rd} !== {32'd2, 32'd0, !inr, exp_rd}) begin
                errors++; $display("FAIL rand_resp[%0d]: got lat=%0d oth=%0d err=%b %h want lat=2 oth=0 err=%b %h",
                                   t, lat, oth, er, rd, !inr, exp_rd);
            end
            checks++;
            if (we_n !== exp_n || (exp_n == 1 && {wd, ad, pc} !== {exp_wd, addr, pcv})) begin
                errors++; $display("FAIL rand_write[%0d]: got n=%0d %h@%h pc=%h want n=%0d %h@%h pc=%h",
                                   t, we_n, wd, ad, pc, exp_n, exp_wd, addr, pcv);
            end
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
            if (mem[4080 + i] !== ref_mem[4080 + i]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_mem_image: got %0d bad words want 0", bad); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; preload = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_be = 4'd0; p0_addr = 32'd0; p0_wdata = 32'd0; p0_pc = 32'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_be = 4'd0; p1_addr = 32'd0; p1_wdata = 32'd0; p1_pc = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        test_reset();
        test_write_read();
        test_byte_merge();
        test_starvation();
        test_out_of_range();
        test_reset_mid_access();
        test_idle_be0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
